// File: rtl/pu_flow_mem_arb.sv
// Shared per-flow scratch memory: per-PU request FIFOs, round-robin arbiter and
// a two-stage atomic read-modify-write pipeline onto one RAM, cleared after reset.
module pu_flow_mem_arb #(
    parameter int NUM_OF_PU   = 16,
    parameter int PU_ID_NBITS = 4,
    parameter int WIDTH_NBITS = 32,
    parameter int FID_NBITS   = 10,
    parameter int WORD_NBITS  = 4,
    parameter int FIFO_NBITS  = 1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_OF_PU-1:0]              req_valid,
    output logic [NUM_OF_PU-1:0]              req_ready,
    input  logic [2*NUM_OF_PU-1:0]            req_op,
    input  logic [FID_NBITS*NUM_OF_PU-1:0]    req_fid,
    input  logic [WORD_NBITS*NUM_OF_PU-1:0]   req_word,
    input  logic [WIDTH_NBITS*NUM_OF_PU-1:0]  req_wdata,
    output logic [NUM_OF_PU-1:0]              ack,
    output logic [WIDTH_NBITS-1:0]            ack_data,
    output logic                              init_done
);

    localparam int ADDR_NBITS = FID_NBITS + WORD_NBITS;
    localparam int DEPTH      = 1 << ADDR_NBITS;
    localparam int FDEPTH     = 1 << FIFO_NBITS;
    localparam int ENT_NBITS  = 2 + ADDR_NBITS + WIDTH_NBITS;
    localparam logic [PU_ID_NBITS:0] NPU = (PU_ID_NBITS+1)'(NUM_OF_PU);

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_FA  = 2'd2;
    localparam logic [1:0] OP_TAS = 2'd3;

    function automatic logic [WIDTH_NBITS-1:0] op_new(input logic [1:0] op,
                                                      input logic [WIDTH_NBITS-1:0] old,
                                                      input logic [WIDTH_NBITS-1:0] wdata);
        case (op)
            OP_WR:   op_new = wdata;
            OP_FA:   op_new = old + wdata;
            OP_TAS:  op_new = (old == '0) ? wdata : old;
            default: op_new = old;
        endcase
    endfunction

    function automatic logic op_writes(input logic [1:0] op, input logic [WIDTH_NBITS-1:0] old);
        case (op)
            OP_WR, OP_FA: op_writes = 1'b1;
            OP_TAS:       op_writes = (old == '0);
            default:      op_writes = 1'b0;
        endcase
    endfunction

    function automatic logic [WIDTH_NBITS-1:0] op_ret(input logic [1:0] op,
                                                      input logic [WIDTH_NBITS-1:0] old);
        op_ret = (op == OP_WR) ? '0 : old;
    endfunction

    logic [NUM_OF_PU-1:0][FIFO_NBITS:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NUM_OF_PU-1:0]               push, empty, full;
    logic [ENT_NBITS-1:0]               fifo_mem [NUM_OF_PU][FDEPTH];

    logic [PU_ID_NBITS-1:0]  rr_q, rr_d;
    logic [PU_ID_NBITS:0]    cand_p1;
    logic                    gnt_vld_p1;
    logic [PU_ID_NBITS-1:0]  gnt_id_p1;
    logic [ENT_NBITS-1:0]    gnt_ent_p1;
    logic [1:0]              gnt_op_p1;
    logic [ADDR_NBITS-1:0]   gnt_addr_p1;
    logic [WIDTH_NBITS-1:0]  gnt_wdata_p1;

    logic                    vld_p2_q, vld_p2_d, fwd_p2_q, fwd_p2_d;
    logic [1:0]              op_p2_q;
    logic [ADDR_NBITS-1:0]   addr_p2_q;
    logic [WIDTH_NBITS-1:0]  wdata_p2_q, fwd_data_p2_q, dout_p2_q;
    logic [PU_ID_NBITS-1:0]  pu_p2_q;
    logic [WIDTH_NBITS-1:0]  old_p2, new_p2, ret_p2;
    logic                    we_p2;

    logic [ADDR_NBITS-1:0]   sweep_q, sweep_d;
    logic                    init_done_q, init_done_d;
    logic [NUM_OF_PU-1:0]    ack_q, ack_d;
    logic [WIDTH_NBITS-1:0]  ack_data_q, ack_data_d;

    logic [WIDTH_NBITS-1:0]  ram [DEPTH];
    logic                    ram_we;
    logic [ADDR_NBITS-1:0]   ram_waddr;
    logic [WIDTH_NBITS-1:0]  ram_wdata;

    always_comb begin
        for (int i = 0; i < NUM_OF_PU; i++) begin
            empty[i]    = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]     = (wr_ptr_q[i][FIFO_NBITS] != rd_ptr_q[i][FIFO_NBITS]) &&
                          (wr_ptr_q[i][FIFO_NBITS-1:0] == rd_ptr_q[i][FIFO_NBITS-1:0]);
            push[i]     = req_valid[i] && !full[i];
            wr_ptr_d[i] = wr_ptr_q[i] + {{FIFO_NBITS{1'b0}}, push[i]};
        end
    end

    assign req_ready = ~full;

    // S1: round-robin grant starting at rr_q; RAM read address issued this cycle
    always_comb begin
        gnt_vld_p1 = 1'b0;
        gnt_id_p1  = '0;
        cand_p1    = '0;
        if (init_done_q) begin
            for (int k = 0; k < NUM_OF_PU; k++) begin
                cand_p1 = {1'b0, rr_q} + (PU_ID_NBITS+1)'(k);
                if (cand_p1 >= NPU) cand_p1 = cand_p1 - NPU;
                if (!gnt_vld_p1 && !empty[cand_p1[PU_ID_NBITS-1:0]]) begin
                    gnt_vld_p1 = 1'b1;
                    gnt_id_p1  = cand_p1[PU_ID_NBITS-1:0];
                end
            end
        end
    end

    assign gnt_ent_p1 = fifo_mem[gnt_id_p1][rd_ptr_q[gnt_id_p1][FIFO_NBITS-1:0]];
    assign {gnt_op_p1, gnt_addr_p1, gnt_wdata_p1} = gnt_ent_p1;

    always_comb begin
        for (int i = 0; i < NUM_OF_PU; i++) begin
            rd_ptr_d[i] = rd_ptr_q[i] +
                          {{FIFO_NBITS{1'b0}}, gnt_vld_p1 && (gnt_id_p1 == PU_ID_NBITS'(i))};
        end
        rr_d = rr_q;
        if (gnt_vld_p1) begin
            rr_d = (({1'b0, gnt_id_p1} + 1'b1) == NPU) ? '0 : gnt_id_p1 + 1'b1;
        end
    end

    // S2: old value (forwarded when S2 wrote the same address last cycle), result, write, ack
    always_comb begin
        old_p2     = fwd_p2_q ? fwd_data_p2_q : dout_p2_q;
        new_p2     = op_new(op_p2_q, old_p2, wdata_p2_q);
        we_p2      = vld_p2_q && op_writes(op_p2_q, old_p2);
        ret_p2     = op_ret(op_p2_q, old_p2);
        vld_p2_d   = gnt_vld_p1;
        fwd_p2_d   = gnt_vld_p1 && we_p2 && (addr_p2_q == gnt_addr_p1);
        ack_d      = '0;
        if (vld_p2_q) ack_d[pu_p2_q] = 1'b1;
        ack_data_d = vld_p2_q ? ret_p2 : '0;
        sweep_d     = init_done_q ? sweep_q : sweep_q + 1'b1;
        init_done_d = init_done_q || (&sweep_q);
        ram_we      = !init_done_q || we_p2;
        ram_waddr   = init_done_q ? addr_p2_q : sweep_q;
        ram_wdata   = init_done_q ? new_p2 : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rr_q        <= '0;
            vld_p2_q    <= 1'b0;
            fwd_p2_q    <= 1'b0;
            ack_q       <= '0;
            ack_data_q  <= '0;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_q        <= rr_d;
            vld_p2_q    <= vld_p2_d;
            fwd_p2_q    <= fwd_p2_d;
            ack_q       <= ack_d;
            ack_data_q  <= ack_data_d;
            sweep_q     <= sweep_d;
            init_done_q <= init_done_d;
        end
    end

    always_ff @(posedge clk) begin
        op_p2_q       <= gnt_op_p1;
        addr_p2_q     <= gnt_addr_p1;
        wdata_p2_q    <= gnt_wdata_p1;
        pu_p2_q       <= gnt_id_p1;
        fwd_data_p2_q <= new_p2;
        for (int i = 0; i < NUM_OF_PU; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr_q[i][FIFO_NBITS-1:0]] <=
                    {req_op[2*i +: 2], req_fid[FID_NBITS*i +: FID_NBITS],
                     req_word[WORD_NBITS*i +: WORD_NBITS], req_wdata[WIDTH_NBITS*i +: WIDTH_NBITS]};
            end
        end
    end

    // Read-first RAM: a same-edge write is not visible to the read, hence the forward path
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        dout_p2_q <= ram[gnt_addr_p1];
    end

    assign ack       = ack_q;
    assign ack_data  = ack_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_pu_flow_mem_arb.sv
// Bench for pu_flow_mem_arb: directed scenarios plus random traffic checked against
// a queue-based model of the FIFOs, round-robin grant order and atomic memory semantics.
module tb_pu_flow_mem_arb;
    localparam int NPU   = 16;
    localparam int FIDB  = 3;
    localparam int WORDB = 2;
    localparam int DEPTH = 1 << (FIDB + WORDB);

    logic              clk;
    logic              rstn;
    logic [NPU-1:0]    req_valid;
    logic [NPU-1:0]    req_ready;
    logic [2*NPU-1:0]  req_op;
    logic [FIDB*NPU-1:0]  req_fid;
    logic [WORDB*NPU-1:0] req_word;
    logic [32*NPU-1:0] req_wdata;
    logic [NPU-1:0]    ack;
    logic [31:0]       ack_data;
    logic              init_done;

    pu_flow_mem_arb #(
        .NUM_OF_PU(NPU), .PU_ID_NBITS(4), .WIDTH_NBITS(32),
        .FID_NBITS(FIDB), .WORD_NBITS(WORDB), .FIFO_NBITS(1)
    ) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_fid(req_fid), .req_word(req_word), .req_wdata(req_wdata),
        .ack(ack), .ack_data(ack_data), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        int          pu;
        logic [31:0] d;
        int          cyc;
    } ack_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    req_t        mq [NPU][$];
    logic [31:0] mm [DEPTH];
    int          rr;
    int          init_cnt;
    bit          pipe_v, exp_v;
    int          pipe_pu, exp_pu;
    logic [31:0] pipe_d, exp_d;
    ack_t        alog [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NPU; i++) mq[i].delete();
        for (int a = 0; a < DEPTH; a++) mm[a] = 32'h0;
        rr = 0; init_cnt = 0;
        pipe_v = 0; exp_v = 0; pipe_pu = 0; exp_pu = 0; pipe_d = 0; exp_d = 0;
    endtask

    // One edge of the reference: grant from pre-edge queues, atomic op in grant order.
    task automatic model_step();
        int   g;
        bit   rdy [NPU];
        req_t r;
        logic [31:0] old;
        g = -1;
        for (int i = 0; i < NPU; i++) rdy[i] = (mq[i].size() < 2);
        if (init_cnt >= DEPTH) begin
            for (int k = 0; k < NPU; k++) begin
                if (g < 0 && mq[(rr + k) % NPU].size() > 0) g = (rr + k) % NPU;
            end
        end
        exp_v = pipe_v; exp_pu = pipe_pu; exp_d = pipe_d;
        pipe_v = 0;
        if (g >= 0) begin
            r   = mq[g].pop_front();
            old = mm[r.addr];
            case (r.op)
                2'd0: pipe_d = old;
                2'd1: begin mm[r.addr] = r.data; pipe_d = 0; end
                2'd2: begin mm[r.addr] = old + r.data; pipe_d = old; end
                default: begin if (old == 0) mm[r.addr] = r.data; pipe_d = old; end
            endcase
            pipe_v = 1; pipe_pu = g;
            rr = (g + 1) % NPU;
        end
        for (int i = 0; i < NPU; i++) begin
            if (req_valid[i] && rdy[i]) begin
                r.op   = req_op[2*i +: 2];
                r.addr = {req_fid[FIDB*i +: FIDB], req_word[WORDB*i +: WORDB]};
                r.data = req_wdata[32*i +: 32];
                mq[i].push_back(r);
            end
        end
        if (init_cnt < DEPTH) init_cnt++;
    endtask

    task automatic cycle();
        logic [NPU-1:0] erdy, eack;
        logic [31:0]    edat;
        for (int i = 0; i < NPU; i++) erdy[i] = (mq[i].size() < 2);
        eack = exp_v ? (NPU'(1) << exp_pu) : '0;
        edat = exp_v ? exp_d : 32'h0;
        chk("req_ready", 64'(req_ready), 64'(erdy));
        chk("init_done", 64'(init_done), 64'(init_cnt >= DEPTH));
        chk("ack", 64'(ack), 64'(eack));
        chk("ack_data", 64'(ack_data), 64'(edat));
        if (ack != 0) begin
            ack_t e;
            e.pu = -1;
            for (int i = 0; i < NPU; i++) if (ack[i]) e.pu = i;
            e.d = ack_data; e.cyc = cyc;
            alog.push_back(e);
        end
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_op = '0; req_fid = '0; req_word = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int pu, input logic [1:0] op, input int fid, input int word,
                           input logic [31:0] d);
        req_valid[pu]              = 1'b1;
        req_op[2*pu +: 2]          = op;
        req_fid[FIDB*pu +: FIDB]   = FIDB'(fid);
        req_word[WORDB*pu +: WORDB] = WORDB'(word);
        req_wdata[32*pu +: 32]     = d;
    endtask

    function automatic bit model_busy();
        bit b;
        b = pipe_v || exp_v;
        for (int i = 0; i < NPU; i++) if (mq[i].size() > 0) b = 1;
        return b;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        clear_reqs();
        while (model_busy() && n < 300) begin
            cycle();
            n++;
        end
        chk("drain_bound", 64'(model_busy()), 64'(0));
    endtask

    task automatic random_traffic(input int ncyc, input int pct);
        for (int c = 0; c < ncyc; c++) begin
            clear_reqs();
            for (int i = 0; i < NPU; i++) begin
                if ($urandom_range(0, 99) < pct) begin
                    set_req(i, 2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 3),
                            ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 20)));
                end
            end
            cycle();
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tn;
        rstn = 1'b0;
        clear_reqs();
        model_reset();
        @(negedge clk);
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_ack_data", 64'(ack_data), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(16'hFFFF));
        @(negedge clk);
        rstn = 1'b1;
        repeat (DEPTH + 2) cycle();

        // All PUs fetch-add 1 to one address in the same cycle
        alog.delete();
        for (int i = 0; i < NPU; i++) set_req(i, 2'd2, 1, 0, 32'd1);
        cycle();
        drain();
        chk("fa_count", 64'(alog.size()), 64'(16));
        for (int i = 0; i < alog.size() && i < NPU; i++) begin
            chk("fa_pu", 64'(alog[i].pu), 64'(i));
            chk("fa_data", 64'(alog[i].d), 64'(i));
        end
        alog.delete();
        set_req(0, 2'd0, 1, 0, 32'h0);
        cycle();
        drain();
        chk("fa_final", (alog.size() > 0) ? 64'(alog[0].d) : 64'hDEAD, 64'(16));

        // Test-and-set contention
        alog.delete();
        set_req(1, 2'd3, 2, 1, 32'd7);
        set_req(2, 2'd3, 2, 1, 32'd9);
        cycle();
        set_req(1, 2'd0, 2, 1, 32'h0);
        req_valid[2] = 1'b0;
        cycle();
        drain();
        chk("tas_count", 64'(alog.size()), 64'(3));
        if (alog.size() == 3) begin
            chk("tas_pu1", 64'(alog[0].pu), 64'(1));
            chk("tas_ret1", 64'(alog[0].d), 64'(0));
            chk("tas_pu2", 64'(alog[1].pu), 64'(2));
            chk("tas_ret2", 64'(alog[1].d), 64'(7));
            chk("tas_final", 64'(alog[2].d), 64'(7));
        end

        // Latency and back-to-back same-address forwarding
        alog.delete();
        tn = cyc + 1;
        set_req(3, 2'd1, 5, 2, 32'hDEADBEEF);
        cycle();
        set_req(3, 2'd0, 5, 2, 32'h0);
        cycle();
        drain();
        chk("lat_count", 64'(alog.size()), 64'(2));
        if (alog.size() == 2) begin
            chk("lat_wr_cyc", 64'(alog[0].cyc), 64'(tn + 2));
            chk("lat_wr_data", 64'(alog[0].d), 64'(0));
            chk("lat_rd_cyc", 64'(alog[1].cyc), 64'(tn + 3));
            chk("lat_rd_data", 64'(alog[1].d), 64'hDEADBEEF);
        end

        // Back-pressure: PU0 held valid while the others saturate the arbiter
        for (int c = 0; c < 10; c++) begin
            clear_reqs();
            for (int i = 0; i < NPU; i++)
                set_req(i, 2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3), $urandom);
            if (c == 2) chk("bp_ready0", 64'(req_ready[0]), 64'(0));
            cycle();
        end
        drain();

        random_traffic(300, 60);
        random_traffic(200, 8);

        // Reset with operations in flight
        set_req(5, 2'd1, 3, 1, 32'h11);
        set_req(6, 2'd1, 3, 2, 32'h22);
        set_req(7, 2'd1, 3, 3, 32'h33);
        cycle();
        clear_reqs();
        cycle();
        rstn = 1'b0;
        #1;
        chk("mid_ack", 64'(ack), 64'(0));
        chk("mid_ack_data", 64'(ack_data), 64'(0));
        chk("mid_init_done", 64'(init_done), 64'(0));
        chk("mid_ready", 64'(req_ready), 64'(16'hFFFF));
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("mid_hold_ack", 64'(ack), 64'(0));
        end
        @(negedge clk);
        rstn = 1'b1;
        alog.delete();
        repeat (DEPTH) cycle();

        // Every address reads back zero after the new sweep
        for (int a = 0; a < DEPTH; a++) begin
            clear_reqs();
            set_req(a % NPU, 2'd0, a >> WORDB, a % (1 << WORDB), 32'h0);
            cycle();
        end
        drain();
        chk("init_count", 64'(alog.size()), 64'(DEPTH));
        for (int i = 0; i < alog.size(); i++) chk("init_zero", 64'(alog[i].d), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
